// File: rtl/mem_arbiter_multi.sv
// mem_arbiter_multi: per-peripheral request FIFOs arbitrated (fixed or round-robin) onto one memory port, in-order read return.
// Optional MEM_ARB_STATS_EN adds grant_count, a saturating per-peripheral accept counter.
module mem_arbiter_multi #(
   parameter int ADDRESS_WIDTH  = 25,
   parameter int DATA_WIDTH     = 8,
   parameter int PERIPHERALS    = 2,
   parameter int REQ_FIFO_DEPTH = 32,
   parameter int TAG_FIFO_DEPTH = 4,
   parameter int ARB_MODE       = 0
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [PERIPHERALS*ADDRESS_WIDTH-1:0] address,
   input  logic [PERIPHERALS-1:0]               wr,
   input  logic [PERIPHERALS*DATA_WIDTH-1:0]    data_in,
   input  logic [PERIPHERALS-1:0]               data_in_ready,
   output logic [PERIPHERALS-1:0]               fifo_full,
   output logic [DATA_WIDTH-1:0]                data_out,
   output logic [PERIPHERALS-1:0]               data_out_ready,
   output logic [ADDRESS_WIDTH-1:0]             mem_address,
   output logic                                 mem_wr,
   output logic [DATA_WIDTH-1:0]                mem_wdata,
   output logic                                 mem_req,
   input  logic                                 mem_ready,
   input  logic [DATA_WIDTH-1:0]                mem_rdata,
   input  logic                                 mem_rvalid
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [PERIPHERALS*16-1:0]            grant_count
`endif
);
   localparam int AW  = ADDRESS_WIDTH;
   localparam int DW  = DATA_WIDTH;
   localparam int P   = PERIPHERALS;
   localparam int IW  = (P > 1) ? $clog2(P) : 1;
   localparam int RPW = $clog2(REQ_FIFO_DEPTH);
   localparam int TPW = $clog2(TAG_FIFO_DEPTH);
   localparam int EW  = 1 + AW + DW;

   logic [EW-1:0]  head [P];
   logic [P-1:0]   elig, pop;
   logic [IW-1:0]  win, rr_q, src_q;
   logic           found, slot_free, grant, tag_push, tag_pop, tag_room;
   logic           mem_req_q, mem_wr_q;
   logic [AW-1:0]  mem_addr_q;
   logic [DW-1:0]  mem_wdata_q, dout_q;
   logic [P-1:0]   dout_rdy_q;
   logic [TPW-1:0] tag_wp_q, tag_rp_q;
   logic [TPW:0]   tag_cnt_q, tag_cnt_d;
   logic [IW-1:0]  tag_mem_q [TAG_FIFO_DEPTH];

   assign slot_free = ~mem_req_q | mem_ready;
   assign tag_push  = mem_req_q & mem_ready & ~mem_wr_q;
   assign tag_pop   = mem_rvalid & (tag_cnt_q != '0);
   assign tag_cnt_d = tag_cnt_q + (TPW+1)'(tag_push) - (TPW+1)'(tag_pop);
   // A read granted now is pushed later, so it needs room after this edge's push/pop settle.
   assign tag_room  = tag_cnt_d < (TPW+1)'(TAG_FIFO_DEPTH);

   for (genvar i = 0; i < P; i++) begin : g_req
      logic [EW-1:0]  mem_q [REQ_FIFO_DEPTH];
      logic [RPW-1:0] wp_q, rp_q;
      logic [RPW:0]   cnt_q, cnt_d;
      logic           full_q, push;
      assign push      = data_in_ready[i] & ~full_q;
      assign cnt_d     = cnt_q + (RPW+1)'(push) - (RPW+1)'(pop[i]);
      assign head[i]   = mem_q[rp_q];
      assign elig[i]   = (cnt_q != '0) & (mem_q[rp_q][EW-1] | tag_room);
      assign fifo_full[i] = full_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
         end else begin
            wp_q   <= wp_q + RPW'(push);
            rp_q   <= rp_q + RPW'(pop[i]);
            cnt_q  <= cnt_d;
            full_q <= cnt_d == (RPW+1)'(REQ_FIFO_DEPTH);
         end
      end
      always_ff @(posedge clk) begin
         if (push) mem_q[wp_q] <= {wr[i], address[i*AW +: AW], data_in[i*DW +: DW]};
      end
   end

   // Fixed priority scans downward from the top index; round-robin scans upward from rr_q+1.
   function automatic int scan_idx(int k, logic [IW-1:0] rr);
      return (ARB_MODE == 0) ? P - k : (int'(rr) + k) % P;
   endfunction

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= P; k++) begin
         if (!found && elig[IW'(scan_idx(k, rr_q))]) begin
            found = 1'b1;
            win   = IW'(scan_idx(k, rr_q));
         end
      end
   end

   assign grant = slot_free & found;
   assign pop   = grant ? P'(1) << win : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         src_q       <= '0;
         rr_q        <= IW'(P - 1);
      end else if (slot_free) begin
         mem_req_q <= grant;
         if (grant) begin
            {mem_wr_q, mem_addr_q, mem_wdata_q} <= head[win];
            src_q <= win;
            rr_q  <= win;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_wp_q   <= '0;
         tag_rp_q   <= '0;
         tag_cnt_q  <= '0;
         dout_q     <= '0;
         dout_rdy_q <= '0;
      end else begin
         tag_wp_q   <= tag_wp_q + TPW'(tag_push);
         tag_rp_q   <= tag_rp_q + TPW'(tag_pop);
         tag_cnt_q  <= tag_cnt_d;
         dout_rdy_q <= tag_pop ? P'(1) << tag_mem_q[tag_rp_q] : '0;
         if (tag_pop) dout_q <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_push) tag_mem_q[tag_wp_q] <= src_q;
   end

   assign mem_req        = mem_req_q;
   assign mem_wr         = mem_wr_q;
   assign mem_address    = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign data_out       = dout_q;
   assign data_out_ready = dout_rdy_q;

`ifdef MEM_ARB_STATS_EN
   for (genvar i = 0; i < P; i++) begin : g_stat
      logic [15:0] cnt_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) cnt_q <= '0;
         else if (mem_req_q && mem_ready && src_q == IW'(i) && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      assign grant_count[i*16 +: 16] = cnt_q;
   end
`endif
endmodule

// File: tb/tb_mem_arbiter_multi.sv
// tb_mem_arbiter_multi: scoreboard bench for mem_arbiter_multi (2-port fixed priority, plus a 3-port round-robin instance).
module tb_mem_arbiter_multi;
   localparam int AW = 25;
   localparam int DW = 8;
   typedef struct {int p; logic w; logic [AW-1:0] a; logic [DW-1:0] d;} req_t;
   typedef struct {int p; logic [DW-1:0] d;} rd_t;
   typedef struct {int due; logic [DW-1:0] d;} ret_t;
   typedef struct {logic [1:0] r; logic [DW-1:0] d;} dlog_t;

   logic clk = 0, reset_n = 0;
   logic [2*AW-1:0] address = '0;
   logic [1:0] wr = '0, data_in_ready = '0, fifo_full, data_out_ready;
   logic [2*DW-1:0] data_in = '0;
   logic [DW-1:0] data_out, mem_wdata, mem_rdata = '0;
   logic [AW-1:0] mem_address;
   logic mem_wr, mem_req, mem_ready = 1'b1, mem_rvalid = 1'b0;

   logic [3*AW-1:0] r_address = '0;
   logic [2:0] r_wr = '0, r_dir = '0, r_full, r_dor;
   logic [3*DW-1:0] r_din = '0;
   logic [DW-1:0] r_dout, r_mem_wdata;
   logic [AW-1:0] r_mem_address;
   logic r_mem_wr, r_mem_req;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] gc;
   logic [47:0] r_gc;
`endif

   req_t exq[$];
   rd_t exrd[$];
   ret_t retq[$];
   dlog_t dlog[$];
   int acc_log[$];
   logic [DW-1:0] rlog[$];
   int checks = 0, errors = 0, cyc = 0, out_cnt = 0, rd_acc = 0;
   bit hold = 0, lat_rand = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_multi dut (
      .clk(clk), .reset_n(reset_n), .address(address), .wr(wr), .data_in(data_in),
      .data_in_ready(data_in_ready), .fifo_full(fifo_full), .data_out(data_out),
      .data_out_ready(data_out_ready), .mem_address(mem_address), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
`ifdef MEM_ARB_STATS_EN
      , .grant_count(gc)
`endif
   );

   mem_arbiter_multi #(.PERIPHERALS(3), .ARB_MODE(1)) dut_rr (
      .clk(clk), .reset_n(reset_n), .address(r_address), .wr(r_wr), .data_in(r_din),
      .data_in_ready(r_dir), .fifo_full(r_full), .data_out(r_dout),
      .data_out_ready(r_dor), .mem_address(r_mem_address), .mem_wr(r_mem_wr),
      .mem_wdata(r_mem_wdata), .mem_req(r_mem_req), .mem_ready(1'b1),
      .mem_rdata(8'h00), .mem_rvalid(1'b0)
`ifdef MEM_ARB_STATS_EN
      , .grant_count(r_gc)
`endif
   );

   // Memory contents as seen by the bench: every address reads back a fixed function of itself.
   function automatic logic [DW-1:0] mem_f(logic [AW-1:0] a);
      return a[7:0] + {4'h0, a[7:4]};
   endfunction

   function automatic int first_req(int p);
      foreach (exq[k]) if (exq[k].p == p) return k;
      return -1;
   endfunction

   function automatic int first_rd(int p);
      foreach (exrd[k]) if (exrd[k].p == p) return k;
      return -1;
   endfunction

   task automatic chk(string n, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] d, bit model);
      wr[p] = w;
      address[p*AW +: AW] = a;
      data_in[p*DW +: DW] = d;
      data_in_ready[p] = 1'b1;
      if (model) begin
         exq.push_back('{p, w, a, d});
         if (!w) exrd.push_back('{p, mem_f(a)});
      end
   endtask

   task automatic drain(string n);
      int t;
      t = 0;
      while ((exq.size() != 0 || exrd.size() != 0) && t < 3000) begin
         tick();
         t++;
      end
      chk(n, exq.size() + exrd.size(), 0);
   endtask

   // Request monitor: every accepted memory request must be the oldest outstanding one of some peripheral.
   always @(negedge clk) begin
      int hit, k;
      if (reset_n && mem_req && mem_ready) begin
         hit = -1;
         for (int p = 0; p < 2; p++) begin
            k = first_req(p);
            if (hit < 0 && k >= 0 && exq[k].w == mem_wr && exq[k].a == mem_address && (!mem_wr || exq[k].d == mem_wdata)) begin
               hit = p;
               exq.delete(k);
            end
         end
         checks++;
         if (hit < 0) begin
            errors++;
            $display("FAIL mem_accept: got wr=%b addr=%h data=%h, required a queued head request", mem_wr, mem_address, mem_wdata);
         end
         acc_log.push_back(hit);
         if (!mem_wr) begin
            out_cnt++;
            rd_acc++;
            retq.push_back('{cyc + 1 + (lat_rand ? int'($urandom_range(1, 5)) : 3), mem_f(mem_address)});
            checks++;
            if (out_cnt > 4) begin
               errors++;
               $display("FAIL outstanding_reads: got %0d required <= 4", out_cnt);
            end
         end
      end
   end

   // Return monitor: each data_out_ready strobe must match the oldest pending read of that peripheral.
   always @(negedge clk) begin
      int p, k;
      if (reset_n && data_out_ready != 2'b00) begin
         p = data_out_ready == 2'b01 ? 0 : data_out_ready == 2'b10 ? 1 : -1;
         k = p < 0 ? -1 : first_rd(p);
         dlog.push_back('{data_out_ready, data_out});
         checks++;
         if (k < 0 || exrd[k].d != data_out) begin
            errors++;
            $display("FAIL read_return: got ready=%b data=%h, required %s", data_out_ready, data_out,
                     k < 0 ? "no strobe" : $sformatf("data=%h", exrd[k].d));
         end else exrd.delete(k);
      end
   end

   always @(negedge clk) if (reset_n && r_mem_req) rlog.push_back(r_mem_wdata);

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (!hold && retq.size() > 0 && retq[0].due <= cyc + 1 && (!lat_rand || $urandom_range(0, 3) != 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata = retq[0].d;
            void'(retq.pop_front());
            out_cnt--;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_fifo_full", fifo_full, 0);
      chk("rst_dout_ready", data_out_ready, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_mem_address", mem_address, 0);
      @(negedge clk) reset_n = 1'b1;
      tick();
      // asynchronous reset while a request is held on the memory port
      mem_ready = 1'b0;
      strobe(0, 1'b1, 25'h77, 8'h33, 1'b0);
      tick();
      data_in_ready = '0;
      tick();
      chk("midburst_req_up", mem_req, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_req", mem_req, 0);
      chk("async_rst_wr", mem_wr, 0);
      chk("async_rst_addr", mem_address, 0);
      chk("async_rst_wdata", mem_wdata, 0);
      chk("async_rst_full", fifo_full, 0);
      @(negedge clk) reset_n = 1'b1;
      mem_ready = 1'b1;
      tick();
      // single write with latency
      strobe(1, 1'b1, 25'h0001234, 8'hA5, 1'b1);
      tick();
      data_in_ready = '0;
      chk("wr_latency_e0", mem_req, 0);
      tick();
      chk("wr_req_e1", mem_req, 1);
      chk("wr_addr", mem_address, 25'h0001234);
      chk("wr_data", mem_wdata, 8'hA5);
      chk("wr_wr", mem_wr, 1);
      tick();
      chk("wr_req_one_cycle", mem_req, 0);
      drain("single_drain");
      // fixed priority
      acc_log.delete();
      for (int k = 0; k < 4; k++) begin
         strobe(0, 1'b1, 25'h100 + AW'(k), 8'h40 + DW'(k), 1'b1);
         strobe(1, 1'b1, 25'h200 + AW'(k), 8'h80 + DW'(k), 1'b1);
         tick();
         data_in_ready = '0;
      end
      drain("prio_drain");
      chk("prio_count", acc_log.size(), 8);
      for (int k = 0; k < 8; k++) chk($sformatf("prio_order%0d", k), acc_log[k], k < 4 ? 1 : 0);
      // round-robin on the 3-port instance
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 3; p++) begin
            r_wr[p] = 1'b1;
            r_address[p*AW +: AW] = AW'(p * 16 + k);
            r_din[p*DW +: DW] = DW'(p * 16 + k);
         end
         r_dir = 3'b111;
         tick();
         r_dir = '0;
      end
      repeat (15) tick();
      chk("rr_count", rlog.size(), 9);
      for (int k = 0; k < 9; k++) chk($sformatf("rr_order%0d", k), rlog[k], (k % 3) * 16 + k / 3);
      // reads with fixed 3-cycle return latency
      dlog.delete();
      strobe(0, 1'b0, 25'h10, 8'h00, 1'b1);
      tick();
      data_in_ready = '0;
      strobe(1, 1'b0, 25'h20, 8'h00, 1'b1);
      tick();
      data_in_ready = '0;
      drain("read_drain");
      chk("rd_count", dlog.size(), 2);
      chk("rd0_ready", dlog[0].r, 2'b01);
      chk("rd0_data", dlog[0].d, 8'h11);
      chk("rd1_ready", dlog[1].r, 2'b10);
      chk("rd1_data", dlog[1].d, 8'h22);
      // tag FIFO limit: fifth read waits for a return
      hold = 1'b1;
      rd_acc = 0;
      for (int k = 0; k < 5; k++) begin
         strobe(0, 1'b0, 25'h30 + AW'(k), 8'h00, 1'b1);
         tick();
         data_in_ready = '0;
      end
      repeat (20) tick();
      chk("tag_limit_4", rd_acc, 4);
      hold = 1'b0;
      drain("tag_drain");
      chk("tag_limit_5", rd_acc, 5);
      // backpressure: 33 fit (1 on the port + 32 queued), 34th dropped
      mem_ready = 1'b0;
      for (int k = 0; k < 34; k++) begin
         strobe(0, 1'b1, 25'h400, DW'(k), k < 33);
         tick();
         data_in_ready = '0;
      end
      chk("bp_full", fifo_full, 2'b01);
      chk("bp_held", mem_wdata, 0);
      mem_ready = 1'b1;
      drain("bp_drain");
      chk("bp_not_full", fifo_full, 0);
      // randomized mixed traffic
      lat_rand = 1'b1;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++)
            if (!fifo_full[p] && $urandom_range(0, 2) == 0)
               strobe(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b1);
         mem_ready = $urandom_range(0, 3) != 0;
         tick();
         data_in_ready = '0;
      end
      mem_ready = 1'b1;
      drain("random_drain");
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
